// File: rtl/pc_align_if.sv
// PC alignment pipeline bus: the PC generator drives the master side, and the pipeline takes the slave side.
// Widths must match the pc_align_pipe parameters they connect to.
interface pc_align_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 work_ena;
  logic [PC_WIDTH-1:0]  pc_i;
  logic                 pc_valid_i;
  logic                 stall;
  logic                 flush;
  logic                 pc_jump;
  logic [PC_WIDTH-1:0]  pc_target;
  logic [PC_WIDTH-1:0]  pc_o;
  logic                 pc_valid_o;
  logic [CNT_WIDTH-1:0] kill_cnt;

  modport master (
    output work_ena, pc_i, pc_valid_i, stall, flush, pc_jump, pc_target,
    input  pc_o, pc_valid_o, kill_cnt
  );

  modport slave (
    input  work_ena, pc_i, pc_valid_i, stall, flush, pc_jump, pc_target,
    output pc_o, pc_valid_o, kill_cnt
  );
endinterface

// File: rtl/pc_align_pipe.sv
// Delays {pc, valid} by DEPTH registers to match fetch latency, and counts discarded slots with saturation.
// Latency pc_i->pc_o is DEPTH cycles; stall holds every stage; outputs come only from registers.
module pc_align_pipe #(
  parameter int                     PC_WIDTH  = 32,
  parameter int                     DEPTH     = 2,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
  parameter int                     CNT_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  pc_align_if.slave bus
);

  localparam logic [CNT_WIDTH+2:0] KILL_MAX = {3'b000, {CNT_WIDTH{1'b1}}};

  logic [PC_WIDTH-1:0]  st_pc [DEPTH];
  logic [DEPTH-1:0]     st_v;
  logic [CNT_WIDTH-1:0] kill_q;
  logic [2:0]           kill_n;
  logic [CNT_WIDTH+2:0] kill_sum;

  // A jump spares the output stage, since it is overwritten with the target, not discarded.
  always_comb begin
    kill_n = '0;
    if (bus.pc_jump) begin
      kill_n = {2'b00, bus.pc_valid_i};
      for (int k = 0; k < DEPTH - 1; k++) kill_n = kill_n + {2'b00, st_v[k]};
    end else if (bus.flush) begin
      kill_n = {2'b00, bus.pc_valid_i};
      for (int k = 0; k < DEPTH; k++) kill_n = kill_n + {2'b00, st_v[k]};
    end
    kill_sum = {3'b000, kill_q} + {{CNT_WIDTH{1'b0}}, kill_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) st_pc[k] <= RESET_PC;
      st_v   <= '0;
      kill_q <= '0;
    end else if (!bus.work_ena) begin
      for (int k = 0; k < DEPTH; k++) st_pc[k] <= RESET_PC;
      st_v <= '0;
    end else begin
      kill_q <= (kill_sum > KILL_MAX) ? '1 : kill_sum[CNT_WIDTH-1:0];
      if (bus.pc_jump) begin
        for (int k = 0; k < DEPTH - 1; k++) st_v[k] <= 1'b0;
        st_pc[DEPTH-1] <= bus.pc_target;
        st_v[DEPTH-1]  <= 1'b1;
      end else if (bus.flush) begin
        st_v <= '0;
      end else if (!bus.stall) begin
        st_pc[0] <= bus.pc_i;
        st_v[0]  <= bus.pc_valid_i;
        for (int k = 1; k < DEPTH; k++) begin
          st_pc[k] <= st_pc[k-1];
          st_v[k]  <= st_v[k-1];
        end
      end
    end
  end

  assign bus.pc_o       = st_pc[DEPTH-1];
  assign bus.pc_valid_o = st_v[DEPTH-1];
  assign bus.kill_cnt   = kill_q;

endmodule

// File: tb/tb_pc_align_pipe.sv
// Drives two pipelines (DEPTH=2/16-bit counter, DEPTH=1/2-bit counter/RESET_PC=0x40) with shared stimulus
// and compares each cycle against a queued reference, plus directed value checks.
module tb_pc_align_pipe;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pc_align_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) bus_a ();
  pc_align_if #(.PC_WIDTH(32), .CNT_WIDTH(2))  bus_b ();

  assign bus_b.work_ena   = bus_a.work_ena;
  assign bus_b.pc_i       = bus_a.pc_i;
  assign bus_b.pc_valid_i = bus_a.pc_valid_i;
  assign bus_b.stall      = bus_a.stall;
  assign bus_b.flush      = bus_a.flush;
  assign bus_b.pc_jump    = bus_a.pc_jump;
  assign bus_b.pc_target  = bus_a.pc_target;

  pc_align_pipe #(.PC_WIDTH(32), .DEPTH(2), .RESET_PC(32'h0), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  pc_align_pipe #(.PC_WIDTH(32), .DEPTH(1), .RESET_PC(32'h40), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  // Reference state, indexed by DUT (0 = dut_a, 1 = dut_b).
  int          dep   [2] = '{2, 1};
  int          cmax  [2] = '{65535, 3};
  logic [31:0] rpc   [2] = '{32'h0, 32'h40};
  logic [31:0] m_pc  [2][4];
  logic        m_v   [2][4];
  int          m_cnt [2];
  exp_t        q_a[$];
  exp_t        q_b[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int d);
    int n;
    int disc;
    n    = dep[d];
    disc = 0;
    if (rst) begin
      for (int k = 0; k < n; k++) begin m_pc[d][k] = rpc[d]; m_v[d][k] = 1'b0; end
      m_cnt[d] = 0;
    end else if (!bus_a.work_ena) begin
      for (int k = 0; k < n; k++) begin m_pc[d][k] = rpc[d]; m_v[d][k] = 1'b0; end
    end else if (bus_a.pc_jump) begin
      disc = int'(bus_a.pc_valid_i);
      for (int k = 0; k < n - 1; k++) begin disc += int'(m_v[d][k]); m_v[d][k] = 1'b0; end
      m_pc[d][n-1] = bus_a.pc_target;
      m_v[d][n-1]  = 1'b1;
    end else if (bus_a.flush) begin
      disc = int'(bus_a.pc_valid_i);
      for (int k = 0; k < n; k++) begin disc += int'(m_v[d][k]); m_v[d][k] = 1'b0; end
    end else if (!bus_a.stall) begin
      for (int k = n - 1; k > 0; k--) begin m_pc[d][k] = m_pc[d][k-1]; m_v[d][k] = m_v[d][k-1]; end
      m_pc[d][0] = bus_a.pc_i;
      m_v[d][0]  = bus_a.pc_valid_i;
    end
    m_cnt[d] = (m_cnt[d] + disc > cmax[d]) ? cmax[d] : m_cnt[d] + disc;
  endtask

  // One clock: predict, push, let the edge happen, then pop and compare both DUTs.
  task automatic tick();
    exp_t e;
    model_step(0);
    model_step(1);
    q_a.push_back('{m_pc[0][dep[0]-1], m_v[0][dep[0]-1], m_cnt[0]});
    q_b.push_back('{m_pc[1][dep[1]-1], m_v[1][dep[1]-1], m_cnt[1]});
    @(posedge clk);
    #1;
    if (q_a.size() == 0 || q_b.size() == 0) begin
      chk("sb_empty", 64'(q_a.size() + q_b.size()), 64'd2);
    end else begin
      e = q_a.pop_front();
      chk("a_pc",  64'(bus_a.pc_o),       64'(e.pc));
      chk("a_vld", 64'(bus_a.pc_valid_o), 64'(e.v));
      chk("a_cnt", 64'(bus_a.kill_cnt),   64'(e.cnt));
      e = q_b.pop_front();
      chk("b_pc",  64'(bus_b.pc_o),       64'(e.pc));
      chk("b_vld", 64'(bus_b.pc_valid_o), 64'(e.v));
      chk("b_cnt", 64'(bus_b.kill_cnt),   64'(e.cnt));
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic v);
    bus_a.pc_i       = pc;
    bus_a.pc_valid_i = v;
  endtask

  initial begin
    rst              = 1'b1;
    bus_a.work_ena   = 1'b1;
    bus_a.pc_i       = '0;
    bus_a.pc_valid_i = 1'b0;
    bus_a.stall      = 1'b0;
    bus_a.flush      = 1'b0;
    bus_a.pc_jump    = 1'b0;
    bus_a.pc_target  = '0;

    tick();
    tick();
    chk("rst_pc_b",  64'(bus_b.pc_o), 64'h40);
    chk("rst_vld_a", 64'(bus_a.pc_valid_o), 64'd0);
    chk("rst_cnt_a", 64'(bus_a.kill_cnt), 64'd0);
    rst = 1'b0;

    // Straight shift: two-edge latency on the DEPTH=2 pipe.
    drive(32'h00, 1'b1); tick();
    chk("t1_vld_early", 64'(bus_a.pc_valid_o), 64'd0);
    drive(32'h04, 1'b1); tick();
    chk("t1_pc0",  64'(bus_a.pc_o), 64'h00);
    chk("t1_vld0", 64'(bus_a.pc_valid_o), 64'd1);
    drive(32'h08, 1'b1); tick();
    chk("t1_pc1",  64'(bus_a.pc_o), 64'h04);

    // Stall for three cycles while pc_o shows 0x04.
    drive(32'h0C, 1'b1);
    bus_a.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold", 64'(bus_a.pc_o), 64'h04);
    end
    bus_a.stall = 1'b0;
    tick();
    chk("t2_resume", 64'(bus_a.pc_o), 64'h08);

    // Jump with two valid in flight and a valid input.
    drive(32'h10, 1'b1);
    bus_a.pc_jump   = 1'b1;
    bus_a.pc_target = 32'h100;
    tick();
    chk("t3_pc",  64'(bus_a.pc_o), 64'h100);
    chk("t3_vld", 64'(bus_a.pc_valid_o), 64'd1);
    chk("t3_cnt", 64'(bus_a.kill_cnt), 64'd2);
    chk("t3_b_pc", 64'(bus_b.pc_o), 64'h100);
    bus_a.pc_jump = 1'b0;
    drive(32'h14, 1'b0);
    tick();
    chk("t3_vld_after", 64'(bus_a.pc_valid_o), 64'd0);

    // Flush with both stages valid and a valid input.
    drive(32'h20, 1'b1); tick();
    drive(32'h24, 1'b1); tick();
    drive(32'h28, 1'b1);
    bus_a.flush = 1'b1;
    tick();
    chk("t4_cnt", 64'(bus_a.kill_cnt), 64'd5);
    bus_a.flush = 1'b0;
    drive(32'h2C, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_vld", 64'(bus_a.pc_valid_o), 64'd0);
    end

    // Repeated flushes saturate the 2-bit counter; reset clears it.
    drive(32'h30, 1'b1);
    bus_a.flush = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_sat", 64'(bus_b.kill_cnt), 64'd3);
    bus_a.flush = 1'b0;
    rst = 1'b1;
    tick();
    chk("t5_rst", 64'(bus_b.kill_cnt), 64'd0);
    rst = 1'b0;

    // Disable mid-stream: stages reload, count holds, latency restarts.
    drive(32'h200, 1'b1); bus_a.flush = 1'b1; tick();
    bus_a.flush = 1'b0;
    drive(32'h204, 1'b1); tick();
    drive(32'h208, 1'b1); tick();
    bus_a.work_ena = 1'b0;
    tick();
    chk("t6_pc",   64'(bus_a.pc_o), 64'h0);
    chk("t6_vld",  64'(bus_a.pc_valid_o), 64'd0);
    chk("t6_cnt",  64'(bus_a.kill_cnt), 64'd1);
    chk("t6_b_pc", 64'(bus_b.pc_o), 64'h40);
    tick();
    bus_a.work_ena = 1'b1;
    drive(32'h300, 1'b1); tick();
    chk("t6_vld_wait", 64'(bus_a.pc_valid_o), 64'd0);
    drive(32'h304, 1'b1); tick();
    chk("t6_first", 64'(bus_a.pc_o), 64'h300);

    // Jump + flush + stall together: only the jump's discard counts.
    drive(32'h308, 1'b1); tick();
    bus_a.pc_jump = 1'b1; bus_a.flush = 1'b1; bus_a.stall = 1'b1;
    bus_a.pc_target = 32'h500;
    tick();
    chk("combo_pc",  64'(bus_a.pc_o), 64'h500);
    chk("combo_cnt", 64'(bus_a.kill_cnt), 64'd3);
    // Reset during a redirect wins outright.
    rst = 1'b1;
    tick();
    chk("rst_jump_vld", 64'(bus_a.pc_valid_o), 64'd0);
    rst = 1'b0;
    bus_a.pc_jump = 1'b0; bus_a.flush = 1'b0; bus_a.stall = 1'b0;

    // Random traffic checked only by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      rst              = ($urandom_range(0, 49) == 0);
      bus_a.work_ena   = ($urandom_range(0, 19) != 0);
      bus_a.pc_jump    = ($urandom_range(0, 9) == 0);
      bus_a.flush      = ($urandom_range(0, 7) == 0);
      bus_a.stall      = ($urandom_range(0, 4) == 0);
      bus_a.pc_target  = $urandom;
      drive($urandom, 1'($urandom_range(0, 1)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
